// File: rtl/sha256_w_expander_seq_if.sv
// Stream/control bundle between the SHA-256 schedule expander and its neighbours.
// A word moves on any rising edge where w_valid and w_ready are both high. w_valid
// never waits on w_ready, and w_out/w_idx stay stable while w_valid=1 and w_ready=0.
interface sha256_w_expander_seq_if;
  logic         start;
  logic         pad_mode;
  logic [511:0] block_in;
  logic         abort;
  logic         w_ready;
  logic         w_valid;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         busy;
  logic         done;

  modport master (
    output start, pad_mode, block_in, abort, w_ready,
    input  w_valid, w_out, w_idx, busy, done
  );

  modport slave (
    input  start, pad_mode, block_in, abort, w_ready,
    output w_valid, w_out, w_idx, busy, done
  );
endinterface

// File: rtl/sha256_w_expander_seq.sv
// Sequential SHA-256 message schedule: loads a 512-bit block (or a 256-bit digest
// plus fixed padding) and streams W[0..ROUNDS-1] through a 16-word sliding window.
module sha256_w_expander_seq #(
  parameter int          ROUNDS       = 64,
  parameter logic [31:0] PAD_MSG_BITS = 32'd256
) (
  input  logic                      CLK,
  input  logic                      RST,
  sha256_w_expander_seq_if.slave    bus,
  output logic                      dbg_state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] win [16];
  logic [5:0]  t;
  logic        done_q;
  logic        load, hs, last;
  logic [31:0] new_word;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign load     = (state == IDLE) && bus.start && !bus.abort;
  assign hs       = (state == RUN) && bus.w_ready;
  assign last     = (t == 6'(ROUNDS - 1));
  assign new_word = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = RUN;
      RUN: begin
        // abort wins over a handshake landing in the same cycle
        if (bus.abort)      state_nxt = IDLE;
        else if (hs && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.w_valid = (state == RUN);
    bus.busy    = (state == RUN);
    bus.w_out   = (state == RUN) ? win[0] : 32'h0;
    bus.w_idx   = (state == RUN) ? t : 6'd0;
    bus.done    = done_q;
    dbg_state   = state;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < 16; k++) win[k] <= 32'h0;
      t      <= 6'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        for (int k = 0; k < 16; k++) begin
          if (bus.pad_mode && k == 8)       win[k] <= 32'h8000_0000;
          else if (bus.pad_mode && k == 15) win[k] <= PAD_MSG_BITS;
          else if (bus.pad_mode && k > 8)   win[k] <= 32'h0;
          else                              win[k] <= bus.block_in[511 - 32*k -: 32];
        end
        t <= 6'd0;
      end else if (state == RUN) begin
        if (bus.abort) begin
          t <= 6'd0;
        end else if (hs) begin
          for (int k = 0; k < 15; k++) win[k] <= win[k+1];
          win[15] <= new_word;
          t       <= last ? 6'd0 : t + 6'd1;
          done_q  <= last;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_w_expander_seq.sv
// Directed bench for sha256_w_expander_seq: "abc" and padded-digest schedules,
// backpressure, ignored start, abort, async reset and a ROUNDS=16 build.
module tb_sha256_w_expander_seq;

  logic CLK;
  logic RST;
  logic dbg_state, dbg_state16;

  sha256_w_expander_seq_if ifc ();
  sha256_w_expander_seq_if ifc16 ();

  sha256_w_expander_seq #(.ROUNDS(64)) dut (
    .CLK(CLK), .RST(RST), .bus(ifc), .dbg_state(dbg_state)
  );

  sha256_w_expander_seq #(.ROUNDS(16)) dut16 (
    .CLK(CLK), .RST(RST), .bus(ifc16), .dbg_state(dbg_state16)
  );

  assign ifc16.start    = ifc.start;
  assign ifc16.pad_mode = ifc.pad_mode;
  assign ifc16.block_in = ifc.block_in;
  assign ifc16.abort    = ifc.abort;
  assign ifc16.w_ready  = ifc.w_ready;

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] ref_w [64];
  logic [31:0] got_w [64];

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] PAD_BLK = {256'h0, {8{32'hDEADBEEF}}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule in the textbook W[t-2]/W[t-7]/W[t-15]/W[t-16] form.
  task automatic build_ref(input logic [511:0] blk, input bit pad);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) ref_w[i] = blk[511 - 32*i -: 32];
    if (pad) begin
      ref_w[8] = 32'h80000000;
      for (int i = 9; i < 15; i++) ref_w[i] = 32'h0;
      ref_w[15] = 32'd256;
    end
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(ref_w[i-15], 7) ^ rotr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3);
      s1 = rotr(ref_w[i-2], 17) ^ rotr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10);
      ref_w[i] = s1 + ref_w[i-7] + s0 + ref_w[i-16];
    end
  endtask

  task automatic fill_q(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(ref_w[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_block(input logic [511:0] blk, input bit pad);
    @(negedge CLK);
    ifc.start    = 1'b1;
    ifc.pad_mode = pad;
    ifc.block_in = blk;
    @(negedge CLK);
    ifc.start    = 1'b0;
    ifc.block_in = {16{$urandom()}};
    check("latency_valid", {31'b0, ifc.w_valid}, 32'd1);
    check("latency_idx", {26'b0, ifc.w_idx}, 32'd0);
  endtask

  // Consume n_words, optional random ready, optional start pulse at index start_at.
  task automatic collect(input int n_words, input bit rnd, input int start_at);
    int          got_n = 0;
    int          budget = 0;
    bit          held = 0;
    logic [31:0] prev_w = 32'h0;
    logic [5:0]  prev_i = 6'd0;
    logic [31:0] exp_w;
    while (got_n < n_words && budget < 2000) begin
      if (held) begin
        check("hold_w_out", ifc.w_out, prev_w);
        check("hold_w_idx", {26'b0, ifc.w_idx}, {26'b0, prev_i});
      end
      check("run_valid", {31'b0, ifc.w_valid}, 32'd1);
      check("run_done_low", {31'b0, ifc.done}, 32'd0);
      ifc.w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (start_at >= 0 && int'(ifc.w_idx) == start_at) begin
        ifc.start    = 1'b1;
        ifc.pad_mode = 1'b1;
        ifc.block_in = {16{$urandom()}};
      end else begin
        ifc.start = 1'b0;
      end
      if (ifc.w_valid && ifc.w_ready) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        check("w_idx", {26'b0, ifc.w_idx}, 32'(got_n));
        check("w_out", ifc.w_out, exp_w);
        if (got_n < 64) got_w[got_n] = ifc.w_out;
        got_n++;
        held = 0;
      end else begin
        held   = 1;
        prev_w = ifc.w_out;
        prev_i = ifc.w_idx;
      end
      @(negedge CLK);
      budget++;
    end
    ifc.start    = 1'b0;
    ifc.pad_mode = 1'b0;
    check("word_count", 32'(got_n), 32'(n_words));
    check("done_pulse", {31'b0, ifc.done}, 32'd1);
    check("end_valid", {31'b0, ifc.w_valid}, 32'd0);
    check("end_busy", {31'b0, ifc.busy}, 32'd0);
    @(negedge CLK);
    check("done_single", {31'b0, ifc.done}, 32'd0);
  endtask

  task automatic run_to_idx(input logic [5:0] idx);
    int b = 0;
    ifc.w_ready = 1'b1;
    while (!(ifc.w_valid && ifc.w_idx == idx) && b < 200) begin
      @(negedge CLK);
      b++;
    end
    check("reach_idx", {26'b0, ifc.w_idx}, {26'b0, idx});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST          = 1'b0;
    ifc.start    = 1'b0;
    ifc.pad_mode = 1'b0;
    ifc.block_in = '0;
    ifc.abort    = 1'b0;
    ifc.w_ready  = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_valid", {31'b0, ifc.w_valid}, 32'd0);
    check("rst_w_out", ifc.w_out, 32'd0);
    check("rst_w_idx", {26'b0, ifc.w_idx}, 32'd0);
    check("rst_busy", {31'b0, ifc.busy}, 32'd0);
    check("rst_done", {31'b0, ifc.done}, 32'd0);
    check("rst_state", {31'b0, dbg_state}, 32'd0);
    RST = 1'b1;

    // "abc" block, full-rate consumer
    build_ref(ABC_BLK, 1'b0);
    fill_q(64);
    start_block(ABC_BLK, 1'b0);
    collect(64, 1'b0, -1);
    check("abc_w0", got_w[0], 32'h61626380);
    check("abc_w15", got_w[15], 32'h00000018);
    check("abc_w16", got_w[16], 32'h61626380);
    check("abc_w17", got_w[17], 32'h000F0000);
    check("abc_w18", got_w[18], 32'h7DA86405);

    // pad mode with an all-zero digest; low half of block_in must be ignored
    build_ref(PAD_BLK, 1'b1);
    fill_q(64);
    start_block(PAD_BLK, 1'b1);
    collect(64, 1'b0, -1);
    check("pad_w8", got_w[8], 32'h80000000);
    for (int i = 9; i < 15; i++) check("pad_w9_14", got_w[i], 32'h0);
    check("pad_w15", got_w[15], 32'h00000100);
    check("pad_w16", got_w[16], 32'h0);
    check("pad_w17", got_w[17], 32'h00A00000);

    // random backpressure
    build_ref(ABC_BLK, 1'b0);
    fill_q(64);
    start_block(ABC_BLK, 1'b0);
    collect(64, 1'b1, -1);

    // start pulsed mid-stream is ignored
    fill_q(64);
    start_block(ABC_BLK, 1'b0);
    collect(64, 1'b0, 5);

    // start together with abort in IDLE is ignored
    @(negedge CLK);
    ifc.start    = 1'b1;
    ifc.abort    = 1'b1;
    ifc.block_in = ABC_BLK;
    @(negedge CLK);
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    check("start_abort_valid", {31'b0, ifc.w_valid}, 32'd0);
    check("start_abort_state", {31'b0, dbg_state}, 32'd0);

    // abort at t=20 with a simultaneous handshake, then a clean restart
    start_block(ABC_BLK, 1'b0);
    run_to_idx(6'd20);
    ifc.abort   = 1'b1;
    ifc.w_ready = 1'b1;
    @(negedge CLK);
    ifc.abort = 1'b0;
    check("abort_valid", {31'b0, ifc.w_valid}, 32'd0);
    check("abort_busy", {31'b0, ifc.busy}, 32'd0);
    check("abort_done", {31'b0, ifc.done}, 32'd0);
    @(negedge CLK);
    check("abort_done_later", {31'b0, ifc.done}, 32'd0);
    fill_q(64);
    start_block(ABC_BLK, 1'b0);
    collect(64, 1'b0, -1);

    // asynchronous reset mid-stream
    start_block(ABC_BLK, 1'b0);
    run_to_idx(6'd30);
    RST = 1'b0;
    #1;
    check("arst_valid", {31'b0, ifc.w_valid}, 32'd0);
    check("arst_w_out", ifc.w_out, 32'd0);
    check("arst_w_idx", {26'b0, ifc.w_idx}, 32'd0);
    check("arst_busy", {31'b0, ifc.busy}, 32'd0);
    check("arst_done", {31'b0, ifc.done}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("arst_no_done", {31'b0, ifc.done}, 32'd0);
    check("arst_idle", {31'b0, ifc.w_valid}, 32'd0);

    // ROUNDS=16 build emits W0..W15 only, then done
    build_ref(ABC_BLK, 1'b0);
    ifc.w_ready = 1'b1;
    start_block(ABC_BLK, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("r16_valid", {31'b0, ifc16.w_valid}, 32'd1);
      check("r16_idx", {26'b0, ifc16.w_idx}, 32'(i));
      check("r16_w_out", ifc16.w_out, ref_w[i]);
      @(negedge CLK);
    end
    check("r16_done", {31'b0, ifc16.done}, 32'd1);
    check("r16_end_valid", {31'b0, ifc16.w_valid}, 32'd0);
    @(negedge CLK);
    check("r16_done_single", {31'b0, ifc16.done}, 32'd0);
    repeat (60) @(negedge CLK);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_w_expander_seq.md
Name: sha256_w_expander_seq

Overview:
Sequential SHA-256 message-schedule generator for the double-SHA256 pipeline.
- Loads one 512-bit block and streams W[0]..W[ROUNDS-1], one word per handshake, into a round core.
- Uses a 16-word sliding window instead of the fixed 4-word stage.
- Pad mode synthesises the constant padding of the second (256-bit-message) hash, so only the 256-bit digest is supplied.
- Supports backpressure and a synchronous abort.

Parameters:
ROUNDS, 64, number of schedule words emitted per block; legal range 16..64.
PAD_MSG_BITS, 256, message length in bits written into W[15] when pad mode is used.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
start  input  1  load request; accepted only in IDLE
pad_mode  input  1  sampled with start; 1 = use block_in[511:256] as W0..W7 and constant padding for W8..W15
block_in  input  512  W0 = [511:480] ... W15 = [31:0]
abort  input  1  synchronous cancel; returns the block to IDLE
w_ready  input  1  consumer accepts w_out this cycle
w_valid  output  1  w_out/w_idx hold a valid word
w_out  output  32  current schedule word W[w_idx]
w_idx  output  6  index t of w_out
busy  output  1  high in RUN
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; window and counter cleared; w_valid=0, w_out=0, w_idx=0, busy=0, done=0.
- Registered state:
  - window win[0..15] of 32 bits, where win[k]=W[t+k];
  - counter t (6 bits);
  - state IDLE/RUN.
- IDLE:
  - If start=1 and abort=0: load the window and set t=0; next cycle state=RUN.
  - Normal load: win[k] = block_in word k.
  - Pad load: win[0..7] = block_in[511:256] words; win[8] = 32'h80000000; win[9..14] = 0; win[15] = PAD_MSG_BITS.
  - start with abort=1 is ignored.
- RUN:
  - w_valid=1, busy=1, w_out=win[0], w_idx=t.
  - Latency: first word is valid in the cycle after start is accepted.
  - Throughput: 1 word/cycle while w_ready=1.
- Handshake (w_valid & w_ready):
  - Shift the window: win[k] <= win[k+1], and win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - t <= t+1.
- w_ready=0: window, t, w_out and w_idx hold exactly; the new-word computation has no side effects.
- Last word: handshake with t=ROUNDS-1 → next cycle state=IDLE, w_valid=0, done=1 for exactly one cycle.
- start during RUN is ignored: no reload, no error, pad_mode not resampled.
- abort=1 in RUN:
  - Next cycle state=IDLE, w_valid=0, done=0.
  - Window contents are don't-care; t is cleared to 0.
  - abort has priority over a simultaneous handshake.
- start in the same cycle as done=1 (state already IDLE) is accepted normally, giving back-to-back blocks with a one-cycle bubble.
- Reset asserted mid-RUN: immediately returns to the reset values above; no done pulse.
- W[0..15] are emitted unmodified from the loaded window; W[16..] are computed.

Test Plan:
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), pad_mode=0, w_ready=1 → w_valid the cycle after start; W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000; exactly 64 words, then a single done pulse.
- Pad mode, block_in[511:256]=0 → W8=0x80000000, W9..W14=0, W15=0x00000100, W16=0, W17=0x00A00000.
- Random w_ready (about 50%) on the "abc" block → the accepted word sequence is identical to the w_ready=1 run; w_out/w_idx stable whenever w_ready=0.
- start pulsed at t=5 during RUN → ignored; stream continues with W5, W6, ...; done after word 63.
- abort at t=20 together with w_ready=1 → next cycle w_valid=0, busy=0, no done; a following start reloads cleanly and emits from W0.
- RST pulsed low at t=30 → outputs immediately at reset values; ROUNDS=16 build emits W0..W15 only, then done.
